bypass_bin_scheduler: RTL and testbench

- Sequences the 4-lane combinational bypass-bin decoder (DecodeBinEP) for a multi-bin bypass request (1..16 bins, e.g. a coefficient remainder suffix).
- Splits the request into chunks of up to 4 bins per cycle and owns the m_value register between chunks.
- Feeds fresh bitstream bits to each lane from a bit-buffer interface, stalling when too few bits are available.
- Packs the decoded bins into one result word returned through a valid/ready handshake.

---
 rtl/bypass_bin_scheduler_if.sv | 25 ++
 rtl/bypass_bin_scheduler.sv | 132 +++++++++++++
 tb/tb_bypass_bin_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bypass_bin_scheduler_if.sv
// Request/result handshake bundle for the bypass-bin scheduler.
// The requester (entropy decoder control) is the master; the scheduler is the slave.
interface bypass_bin_scheduler_if #(
    parameter int MAX_BINS = 16,
    parameter int CNT_W    = 5
);
    logic                req_valid;
    logic                req_ready;
    logic [CNT_W-1:0]    req_num;
    logic [8:0]          req_range;
    logic                res_valid;
    logic                res_ready;
    logic [MAX_BINS-1:0] res_bins;
    logic [CNT_W-1:0]    res_count;

    modport master (
        output req_valid, req_num, req_range, res_ready,
        input  req_ready, res_valid, res_bins, res_count
    );

    modport slave (
        input  req_valid, req_num, req_range, res_ready,
        output req_ready, res_valid, res_bins, res_count
    );
endinterface

// File: rtl/bypass_bin_scheduler.sv
// Bypass-bin scheduler: splits a multi-bin bypass request into chunks of up
// to four bins, drives the 4-lane DecodeBinEP datapath, owns m_value between
// chunks and returns the packed bins through a valid/ready result port.
module bypass_bin_scheduler #(
    parameter int MAX_BINS = 16,
    parameter int CNT_W    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_valid,
    input  logic [15:0]            init_value,
    bypass_bin_scheduler_if.slave  bus,
    output logic [8:0]             dp_m_range,
    output logic [1:0]             dp_n_bin,
    output logic [15:0]            dp_m_value_in,
    output logic [3:0]             dp_new_bits,
    input  logic [3:0]             dp_bin_out,
    input  logic [15:0]            dp_m_value_out,
    input  logic [4:0]             bit_level,
    input  logic [3:0]             bit_data,
    output logic [2:0]             bit_pop,
    output logic [15:0]            value_out,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BINS);

    state_t              state, state_nxt;
    logic [15:0]         m_value;
    logic [8:0]          range_q;
    logic [CNT_W-1:0]    remaining;
    logic [CNT_W-1:0]    remaining_nxt;
    logic [CNT_W-1:0]    res_count_q;
    logic [CNT_W-1:0]    num_clamped;
    logic [MAX_BINS-1:0] bins_acc;
    logic [2:0]          chunk;
    logic [3:0]          chunk_bins;
    logic                issue;
    logic                accept;

    // Chunk sizing, issue decision and lane-ordered bin field for this cycle
    always_comb begin
        chunk         = (remaining >= CNT_W'(4)) ? 3'd4 : remaining[2:0];
        issue         = (state == RUN) && (bit_level >= {2'b00, chunk});
        accept        = (state == IDLE) && !init_valid && bus.req_valid;
        num_clamped   = (bus.req_num > MAX_CNT) ? MAX_CNT : bus.req_num;
        remaining_nxt = remaining - CNT_W'(chunk);
        // lane 0 is the first decoded bin, so it lands in the chunk's MSB
        case (chunk)
            3'd1:    chunk_bins = {3'b000, dp_bin_out[0]};
            3'd2:    chunk_bins = {2'b00, dp_bin_out[0], dp_bin_out[1]};
            3'd3:    chunk_bins = {1'b0, dp_bin_out[0], dp_bin_out[1], dp_bin_out[2]};
            3'd4:    chunk_bins = {dp_bin_out[0], dp_bin_out[1], dp_bin_out[2], dp_bin_out[3]};
            default: chunk_bins = 4'b0000;
        endcase
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (num_clamped == '0) ? DONE : RUN;
            RUN:  if (issue && (remaining_nxt == '0)) state_nxt = DONE;
            DONE: if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and per-cycle datapath controls; forced quiet while in reset
    always_comb begin
        bus.req_ready = 1'b0;
        bit_pop       = '0;
        dp_n_bin      = '0;
        if (!rst) begin
            bus.req_ready = (state == IDLE) && !init_valid;
            if (issue) begin
                bit_pop  = chunk;
                dp_n_bin = 2'(chunk - 3'd1);
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // m_value, latched range and bin accumulation across chunks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_value     <= '0;
            range_q     <= '0;
            remaining   <= '0;
            res_count_q <= '0;
            bins_acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_valid) begin
                        m_value <= init_value;
                    end else if (bus.req_valid) begin
                        range_q     <= bus.req_range;
                        remaining   <= num_clamped;
                        res_count_q <= num_clamped;
                        bins_acc    <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        m_value   <= dp_m_value_out;
                        bins_acc  <= (bins_acc << chunk) | MAX_BINS'(chunk_bins);
                        remaining <= remaining_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dp_m_value_in = m_value;
    assign dp_m_range    = range_q;
    assign dp_new_bits   = {bit_data[0], bit_data[1], bit_data[2], bit_data[3]};
    assign bus.res_valid = (state == DONE);
    assign bus.res_bins  = bins_acc;
    assign bus.res_count = res_count_q;
    assign value_out     = m_value;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_bypass_bin_scheduler.sv
// Self-checking bench for bypass_bin_scheduler. A bitstream array models the
// bit buffer; a stub datapath returns each lane's fresh bit as its bin and
// shifts the used bits into m_value, so a request's result is simply the next
// N stream bits and m_value becomes the old value with those bits appended.
module tb_bypass_bin_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_valid;
    logic [15:0] init_value;
    logic [8:0]  dp_m_range;
    logic [1:0]  dp_n_bin;
    logic [15:0] dp_m_value_in;
    logic [3:0]  dp_new_bits;
    logic [3:0]  dp_bin_out;
    logic [15:0] dp_m_value_out;
    logic [4:0]  bit_level;
    logic [3:0]  bit_data;
    logic [2:0]  bit_pop;
    logic [15:0] value_out;
    logic        busy;

    bypass_bin_scheduler_if #(.MAX_BINS(16), .CNT_W(5)) bus ();

    bypass_bin_scheduler #(.MAX_BINS(16), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .init_valid     (init_valid),
        .init_value     (init_value),
        .bus            (bus),
        .dp_m_range     (dp_m_range),
        .dp_n_bin       (dp_n_bin),
        .dp_m_value_in  (dp_m_value_in),
        .dp_new_bits    (dp_new_bits),
        .dp_bin_out     (dp_bin_out),
        .dp_m_value_out (dp_m_value_out),
        .bit_level      (bit_level),
        .bit_data       (bit_data),
        .bit_pop        (bit_pop),
        .value_out      (value_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        stream [0:8191];
    int          rd_ptr = 0;
    logic        force_bins = 1'b0;
    logic [15:0] m_model = '0;
    logic [3:0]  nb_rev;
    logic [3:0]  lane_field;

    // Bit buffer: pops exactly what the scheduler asks for on each edge
    always @(posedge clk) rd_ptr <= rd_ptr + int'(bit_pop);

    assign bit_data = {stream[rd_ptr], stream[rd_ptr+1], stream[rd_ptr+2], stream[rd_ptr+3]};

    // Stub datapath: bin = lane bit; m_value shifts in the used lane bits
    always_comb begin
        nb_rev         = {dp_new_bits[0], dp_new_bits[1], dp_new_bits[2], dp_new_bits[3]};
        lane_field     = nb_rev >> (3 - int'(dp_n_bin));
        dp_m_value_out = (dp_m_value_in << (int'(dp_n_bin) + 1)) | {12'b0, lane_field};
        dp_bin_out     = force_bins ? 4'b0101 : dp_new_bits;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full request. mode 0: bits always plentiful, 1: random bit_level,
    // 2: bit_level=3 for the first two cycles then plentiful.
    task automatic run_req(input int n, input int mode, input bit forced, input int bp);
        int          neff, t, cyc, pops, popped, rem, k_exp;
        logic [15:0] exp_bins, sbits, m_before;
        logic [8:0]  rng;
        logic [31:0] tmp;
        logic        b;
        bit          done;
        neff = (n > 16) ? 16 : n;
        @(negedge clk);
        init_valid    = 1'b0;
        bus.res_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_num   = 5'(n);
        rng           = 9'($urandom);
        bus.req_range = rng;
        bit_level     = 5'd16;
        force_bins    = forced;
        #1;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            @(negedge clk); #1; t++;
        end
        check("req_ready", bus.req_ready, 1);
        check("idle_pop", bit_pop, 0);
        exp_bins = '0;
        sbits    = '0;
        for (int i = 0; i < neff; i++) begin
            b        = forced ? ((i % 2) == 0) : stream[rd_ptr+i];
            exp_bins = {exp_bins[14:0], b};
            sbits    = {sbits[14:0], stream[rd_ptr+i]};
        end
        m_before = m_model;
        tmp      = ({16'b0, m_model} << neff) | {16'b0, sbits};
        m_model  = tmp[15:0];
        @(posedge clk);
        cyc = 0; pops = 0; popped = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.req_valid = 1'b0;
            bus.req_range = 9'($urandom);
            case (mode)
                1:       bit_level = 5'($urandom_range(0, 16));
                2:       bit_level = (cyc <= 2) ? 5'd3 : 5'd16;
                default: bit_level = 5'd16;
            endcase
            init_valid = ($urandom_range(0, 5) == 0);
            init_value = 16'($urandom);
            #1;
            if (bus.res_valid === 1'b1) begin
                done = 1;
            end else begin
                check("range_hold", dp_m_range, rng);
                check("pop_le_level", (bit_pop > bit_level), 0);
                if (bit_pop != 0) begin
                    pops++;
                    popped += int'(bit_pop);
                    check("n_bin_vs_pop", int'(dp_n_bin) + 1, bit_pop);
                end
                if (mode == 0) begin
                    rem   = neff - 4 * (cyc - 1);
                    k_exp = (rem > 4) ? 4 : rem;
                    check("pop_chunk", bit_pop, k_exp);
                    check("n_bin", dp_n_bin, k_exp - 1);
                end
                if (mode == 2 && cyc <= 2) begin
                    check("starve_pop", bit_pop, 0);
                    check("starve_hold", value_out, m_before);
                end
            end
            init_valid = 1'b0;
        end
        check("res_timeout", done, 1);
        if (mode != 1) check("latency", cyc, (neff + 3) / 4 + 1 + ((mode == 2) ? 2 : 0));
        check("chunks", pops, (neff + 3) / 4);
        check("bits_popped", popped, neff);
        check("res_bins", bus.res_bins, exp_bins);
        check("res_count", bus.res_count, neff);
        check("value", value_out, m_model);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            bit_level = 5'($urandom_range(0, 16));
            #1;
            check("bp_valid", bus.res_valid, 1);
            check("bp_bins", bus.res_bins, exp_bins);
            check("bp_count", bus.res_count, neff);
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_pop", bit_pop, 0);
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        #1;
        check("res_valid_last", bus.res_valid, 1);
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1;
        check("back_idle", busy, 0);
        check("res_valid_clear", bus.res_valid, 0);
        check("value_idle", value_out, m_model);
        force_bins = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) stream[i] = 1'($urandom);
        rst           = 1'b1;
        init_valid    = 1'b0;
        init_value    = '0;
        bit_level     = 5'd16;
        bus.req_valid = 1'b0;
        bus.req_num   = '0;
        bus.req_range = '0;
        bus.res_ready = 1'b0;
        #2;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_pop", bit_pop, 0);
        check("rst_n_bin", dp_n_bin, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_value", value_out, 0);
        check("rst_count", bus.res_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic: 10 bins, forced 0101 bins -> 0x2AA
        run_req(10, 0, 1'b1, 0);
        // Bit starvation
        run_req(4, 2, 1'b0, 0);

        // Init has priority over a same-cycle request
        @(negedge clk);
        init_valid    = 1'b1;
        init_value    = 16'h1234;
        bus.req_valid = 1'b1;
        bus.req_num   = 5'd5;
        #1;
        check("init_blocks_req", bus.req_ready, 0);
        @(negedge clk);
        init_valid    = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("init_value", value_out, 16'h1234);
        check("req_after_init", bus.req_ready, 1);
        m_model = 16'h1234;
        run_req(5, 0, 1'b0, 0);

        // Backpressure, zero length, oversize clamp
        run_req(7, 0, 1'b0, 3);
        run_req(0, 0, 1'b0, 1);
        run_req(25, 0, 1'b0, 0);

        // Reset during the second chunk of a 12-bin request
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_num   = 5'd12;
        bit_level     = 5'd16;
        #1;
        check("rr_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        check("rr_chunk1", bit_pop, 4);
        @(negedge clk);
        #1;
        check("rr_chunk2", bit_pop, 4);
        rst = 1'b1;
        #1;
        check("rr_res_valid", bus.res_valid, 0);
        check("rr_busy", busy, 0);
        check("rr_value", value_out, 0);
        check("rr_pop", bit_pop, 0);
        @(negedge clk);
        rst     = 1'b0;
        m_model = '0;
        run_req(9, 0, 1'b0, 0);

        // Randomized requests
        for (int r = 0; r < 40; r++)
            run_req($urandom_range(0, 20), $urandom_range(0, 1), 1'b0, $urandom_range(0, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
